// File: rtl/mc_control_hs.sv
// Multi-cycle MIPS control FSM with handshaked memory/mult-div waits, a bus timeout,
// precise exceptions and interrupts. Emits sequencing strobes only.
module mc_control_hs #(
  parameter int unsigned TMO_MAX = 15,
  parameter int unsigned TMO_W   = 4,
  parameter bit          INT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_rdy,
  input  logic        dmem_rdy,
  input  logic        md_busy,
  input  logic        ovf,
  input  logic        intreq,
  output logic        imem_req,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic [3:0]  npc_op,
  output logic        regwr,
  output logic        dm_req,
  output logic        dm_we,
  output logic        md_start,
  output logic        cp0_we,
  output logic        epc_we,
  output logic        exlset,
  output logic        exlclr,
  output logic [4:0]  exc_code,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3, S_WBLD = 4'd4,
    S_MWR = 4'd5, S_EXE = 4'd6, S_WBALU = 4'd7, S_BR = 4'd8, S_JMP = 4'd9,
    S_MD = 4'd10, S_MF = 4'd11, S_INT = 4'd12, S_EXC = 4'd13
  } state_e;

  typedef enum logic [3:0] {
    C_RI, C_BR, C_JMP, C_ERET, C_LD, C_ST, C_MD, C_MTC0, C_MF, C_ALU
  } cls_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [4:0]       code_q, code_d;

  logic [5:0] op_s, funct_s;
  logic [4:0] rs_s, rt_s;
  cls_e       cls_s;
  logic       ovc_s, link_s, tmo_s;
  logic [3:0] br_npc_s, jmp_npc_s;

  assign op_s    = instr[31:26];
  assign rs_s    = instr[25:21];
  assign rt_s    = instr[20:16];
  assign funct_s = instr[5:0];
  assign tmo_s   = (cnt_q == TMO_W'(TMO_MAX - 1));

  // Instruction class and branch/jump target selects from the IR
  always_comb begin
    cls_s     = C_RI;
    ovc_s     = 1'b0;
    link_s    = 1'b0;
    br_npc_s  = 4'd0;
    jmp_npc_s = 4'd0;
    case (op_s)
      6'h00: begin
        case (funct_s)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: cls_s = C_ALU;
          6'h20, 6'h22: begin cls_s = C_ALU; ovc_s = 1'b1; end
          6'h08: begin cls_s = C_JMP; jmp_npc_s = 4'd9; end
          6'h09: begin cls_s = C_JMP; jmp_npc_s = 4'd10; link_s = 1'b1; end
          6'h10, 6'h12: cls_s = C_MF;
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: cls_s = C_MD;
          default: cls_s = C_RI;
        endcase
      end
      6'h01: begin
        if (rt_s == 5'd0) begin
          cls_s = C_BR; br_npc_s = 4'd6;
        end else if (rt_s == 5'd1) begin
          cls_s = C_BR; br_npc_s = 4'd5;
        end else begin
          cls_s = C_RI;
        end
      end
      6'h02: begin cls_s = C_JMP; jmp_npc_s = 4'd7; end
      6'h03: begin cls_s = C_JMP; jmp_npc_s = 4'd8; link_s = 1'b1; end
      6'h04: begin cls_s = C_BR; br_npc_s = 4'd1; end
      6'h05: begin cls_s = C_BR; br_npc_s = 4'd2; end
      6'h06: begin cls_s = C_BR; br_npc_s = 4'd3; end
      6'h07: begin cls_s = C_BR; br_npc_s = 4'd4; end
      6'h08: begin cls_s = C_ALU; ovc_s = 1'b1; end
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: cls_s = C_ALU;
      6'h10: begin
        if (rs_s == 5'h00) begin
          cls_s = C_MF;
        end else if (rs_s == 5'h04) begin
          cls_s = C_MTC0;
        end else if (instr[25:0] == 26'h2000018) begin
          cls_s = C_ERET; jmp_npc_s = 4'd11;
        end else begin
          cls_s = C_RI;
        end
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: cls_s = C_LD;
      6'h28, 6'h29, 6'h2B: cls_s = C_ST;
      default: cls_s = C_RI;
    endcase
  end

  // Next state, cause code and wait-state counter
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH: begin
        if (imem_rdy) state_d = S_DECODE;
        else if (tmo_s) begin state_d = S_EXC; code_d = 5'd6; end
        else state_d = S_FETCH;
      end
      S_DECODE: begin
        case (cls_s)
          C_BR:          state_d = S_BR;
          C_JMP, C_ERET: state_d = S_JMP;
          C_LD, C_ST:    state_d = S_MADDR;
          C_MD, C_MTC0:  state_d = S_MD;
          C_MF:          state_d = S_MF;
          C_ALU:         state_d = S_EXE;
          default: begin state_d = S_EXC; code_d = 5'd10; end
        endcase
      end
      S_MADDR: begin
        if (cls_s == C_ST) state_d = S_MWR;
        else state_d = S_MRD;
      end
      S_MRD: begin
        if (dmem_rdy) state_d = S_WBLD;
        else if (tmo_s) begin state_d = S_EXC; code_d = 5'd7; end
        else state_d = S_MRD;
      end
      S_MWR: begin
        if (dmem_rdy) state_d = (INT_EN && intreq) ? S_INT : S_FETCH;
        else if (tmo_s) begin state_d = S_EXC; code_d = 5'd7; end
        else state_d = S_MWR;
      end
      S_MD: begin
        if (!md_busy) state_d = (INT_EN && intreq) ? S_INT : S_FETCH;
        else if (tmo_s) begin state_d = S_EXC; code_d = 5'd7; end
        else state_d = S_MD;
      end
      S_EXE: begin
        if (ovc_s && ovf) begin state_d = S_EXC; code_d = 5'd12; end
        else state_d = S_WBALU;
      end
      S_WBLD, S_WBALU, S_BR, S_JMP, S_MF:
        state_d = (INT_EN && intreq) ? S_INT : S_FETCH;
      default: state_d = S_FETCH;
    endcase
    if (state_d == S_INT) code_d = 5'd0;
    else code_d = code_d;
    // Leaving a state restarts the count; staying in a wait state means still not ready
    if (state_d != state_q) cnt_d = '0;
    else if (state_q == S_FETCH || state_q == S_MRD || state_q == S_MWR || state_q == S_MD)
      cnt_d = cnt_q + TMO_W'(1);
    else cnt_d = cnt_q;
  end

  // State, counter and cause register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      code_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // Sequencing strobes decoded from the current state
  always_comb begin
    imem_req = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    npc_op   = 4'd0;
    regwr    = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    md_start = 1'b0;
    cp0_we   = 1'b0;
    epc_we   = 1'b0;
    exlset   = 1'b0;
    exlclr   = 1'b0;
    case (state_q)
      S_FETCH:  begin imem_req = 1'b1; ir_wr = imem_rdy; end
      S_DECODE: pc_wr = 1'b1;
      S_MRD:    dm_req = 1'b1;
      S_MWR:    begin dm_req = 1'b1; dm_we = 1'b1; end
      S_WBLD, S_WBALU, S_MF: regwr = 1'b1;
      S_BR:     begin pc_wr = 1'b1; npc_op = br_npc_s; end
      S_JMP: begin
        pc_wr  = 1'b1;
        npc_op = jmp_npc_s;
        regwr  = (cls_s == C_JMP) && link_s;
        exlclr = (cls_s == C_ERET);
      end
      S_MD: begin
        // The counter is zero only on the first MD cycle: staying implies md_busy was seen
        md_start = (cls_s == C_MD) && (cnt_q == '0);
        cp0_we   = (cls_s == C_MTC0) && !md_busy;
      end
      S_INT, S_EXC: begin
        pc_wr  = 1'b1;
        npc_op = 4'd12;
        epc_we = 1'b1;
        exlset = 1'b1;
      end
      default: imem_req = 1'b0;
    endcase
  end

  assign exc_code = code_q;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_control_hs.sv
// Scoreboarded bench for mc_control_hs: per-cycle expected state/strobe vectors are
// queued as stimulus is applied and compared against the DUT at the falling edge.
module tb_mc_control_hs;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3,
                         S_WBLD = 4'd4, S_MWR = 4'd5, S_EXE = 4'd6, S_WBALU = 4'd7,
                         S_BR = 4'd8, S_JMP = 4'd9, S_MD = 4'd10, S_MF = 4'd11,
                         S_INT = 4'd12, S_EXC = 4'd13;

  // Strobe bits: imem_req ir_wr pc_wr regwr dm_req dm_we md_start cp0_we epc_we exlset exlclr
  localparam logic [10:0] IRQ = 11'h400, IRW = 11'h200, PCW = 11'h100, RW = 11'h080,
                          DRQ = 11'h040, DWE = 11'h020, MDS = 11'h010, CPW = 11'h008,
                          EPC = 11'h006, XCL = 11'h001, NONE = 11'h000;

  // Input bits: imem_rdy dmem_rdy md_busy ovf intreq
  localparam logic [4:0] I_IRDY = 5'b10000, I_DRDY = 5'b01000, I_BUSY = 5'b00100,
                         I_OVF = 5'b00010, I_IRQ = 5'b00001, I_NONE = 5'b00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_rdy, dmem_rdy, md_busy, ovf, intreq;

  logic        imem_req, ir_wr, pc_wr, regwr, dm_req, dm_we, md_start, cp0_we;
  logic        epc_we, exlset, exlclr;
  logic [3:0]  npc_op, state;
  logic [4:0]  exc_code;

  logic        n_imem_req, n_ir_wr, n_pc_wr, n_regwr, n_dm_req, n_dm_we, n_md_start, n_cp0_we;
  logic        n_epc_we, n_exlset, n_exlclr;
  logic [3:0]  n_npc_op, n_state;
  logic [4:0]  n_exc_code;

  logic [23:0] obs_s;
  logic [23:0] exp_q[$];
  logic [3:0]  exp2_q[$];

  int    vectors = 0;
  int    miscompares = 0;
  string test_name = "init";
  int    cyc = 0;

  mc_control_hs #(.TMO_MAX(15), .TMO_W(4), .INT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .md_busy(md_busy), .ovf(ovf), .intreq(intreq), .imem_req(imem_req), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .npc_op(npc_op), .regwr(regwr), .dm_req(dm_req), .dm_we(dm_we),
    .md_start(md_start), .cp0_we(cp0_we), .epc_we(epc_we), .exlset(exlset),
    .exlclr(exlclr), .exc_code(exc_code), .state(state)
  );

  mc_control_hs #(.TMO_MAX(15), .TMO_W(4), .INT_EN(1'b0)) u_dut_noint (
    .clk(clk), .rst(rst), .instr(instr), .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy),
    .md_busy(md_busy), .ovf(ovf), .intreq(intreq), .imem_req(n_imem_req), .ir_wr(n_ir_wr),
    .pc_wr(n_pc_wr), .npc_op(n_npc_op), .regwr(n_regwr), .dm_req(n_dm_req), .dm_we(n_dm_we),
    .md_start(n_md_start), .cp0_we(n_cp0_we), .epc_we(n_epc_we), .exlset(n_exlset),
    .exlclr(n_exlclr), .exc_code(n_exc_code), .state(n_state)
  );

  always #5 clk = ~clk;

  assign obs_s = {state, npc_op, exc_code, imem_req, ir_wr, pc_wr, regwr, dm_req, dm_we,
                  md_start, cp0_we, epc_we, exlset, exlclr};

  task automatic check_vec(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic begin_test(input string name, input logic [31:0] ir);
    test_name = name;
    cyc = 0;
    instr = ir;
  endtask

  // One clock cycle: queue expectations, drive inputs, compare, advance to next falling edge
  task automatic step2(input logic [3:0] st, input logic [3:0] st2, input logic [3:0] npc,
                       input logic [4:0] code, input logic [10:0] fl, input logic [4:0] in);
    exp_q.push_back({st, npc, code, fl});
    exp2_q.push_back(st2);
    {imem_rdy, dmem_rdy, md_busy, ovf, intreq} = in;
    #1;
    check_vec($sformatf("%s[%0d]", test_name, cyc), obs_s, exp_q.pop_front());
    check_vec($sformatf("%s.noint[%0d]", test_name, cyc), {20'd0, n_state},
              {20'd0, exp2_q.pop_front()});
    cyc++;
    @(negedge clk);
  endtask

  task automatic step(input logic [3:0] st, input logic [3:0] npc, input logic [4:0] code,
                      input logic [10:0] fl, input logic [4:0] in);
    step2(st, st, npc, code, fl, in);
  endtask

  task automatic run_n(input int n, input logic [3:0] st, input logic [4:0] code,
                       input logic [10:0] fl, input logic [4:0] in);
    for (int k = 0; k < n; k++) step(st, 4'd0, code, fl, in);
  endtask

  // Assert reset at a falling edge, check the reset values at once, then release
  task automatic do_reset(input string name);
    rst = 1'b0;
    {imem_rdy, dmem_rdy, md_busy, ovf, intreq} = I_NONE;
    #1;
    exp_q.push_back({S_FETCH, 4'd0, 5'd0, IRQ});
    check_vec({name, ".rst"}, obs_s, exp_q.pop_front());
    check_vec({name, ".rst.noint"}, {20'd0, n_state}, 24'd0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    instr = 32'd0;
    {imem_rdy, dmem_rdy, md_busy, ovf, intreq} = I_NONE;
    @(negedge clk);
    do_reset("por");

    begin_test("addu", 32'h00851021);
    step(S_FETCH, 4'd0, 5'd0, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd0, PCW, I_NONE);
    step(S_EXE, 4'd0, 5'd0, NONE, I_NONE);
    step(S_WBALU, 4'd0, 5'd0, RW, I_NONE);
    step(S_FETCH, 4'd0, 5'd0, IRQ, I_NONE);

    begin_test("add_ovf", 32'h00851020);
    step(S_FETCH, 4'd0, 5'd0, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd0, PCW, I_NONE);
    step(S_EXE, 4'd0, 5'd0, NONE, I_OVF);
    step(S_EXC, 4'd12, 5'd12, PCW | EPC, I_NONE);
    step(S_FETCH, 4'd0, 5'd12, IRQ, I_NONE);

    begin_test("beq_int", 32'h10850003);
    step(S_FETCH, 4'd0, 5'd12, IRQ | IRW, I_IRDY | I_IRQ);
    step(S_DECODE, 4'd0, 5'd12, PCW, I_IRQ);
    step(S_BR, 4'd1, 5'd12, PCW, I_IRQ);
    step2(S_INT, S_FETCH, 4'd12, 5'd0, PCW | EPC, I_NONE);
    step(S_FETCH, 4'd0, 5'd0, IRQ, I_NONE);

    do_reset("pre_ftmo");
    begin_test("fetch_tmo", 32'h00000000);
    run_n(15, S_FETCH, 5'd0, IRQ, I_NONE);
    step(S_EXC, 4'd12, 5'd6, PCW | EPC, I_NONE);
    step(S_FETCH, 4'd0, 5'd6, IRQ, I_NONE);

    begin_test("lw", 32'h8C820004);
    step(S_FETCH, 4'd0, 5'd6, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd6, PCW, I_NONE);
    step(S_MADDR, 4'd0, 5'd6, NONE, I_NONE);
    run_n(3, S_MRD, 5'd6, DRQ, I_NONE);
    step(S_MRD, 4'd0, 5'd6, DRQ, I_DRDY);
    step(S_WBLD, 4'd0, 5'd6, RW, I_NONE);
    step(S_FETCH, 4'd0, 5'd6, IRQ, I_NONE);

    begin_test("lw_rst", 32'h8C820004);
    step(S_FETCH, 4'd0, 5'd6, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd6, PCW, I_NONE);
    step(S_MADDR, 4'd0, 5'd6, NONE, I_NONE);
    run_n(2, S_MRD, 5'd6, DRQ, I_NONE);
    do_reset("lw_midwait");

    begin_test("sw_tmo", 32'hAC820004);
    step(S_FETCH, 4'd0, 5'd0, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd0, PCW, I_NONE);
    step(S_MADDR, 4'd0, 5'd0, NONE, I_NONE);
    run_n(15, S_MWR, 5'd0, DRQ | DWE, I_NONE);
    step(S_EXC, 4'd12, 5'd7, PCW | EPC, I_NONE);
    step(S_FETCH, 4'd0, 5'd7, IRQ, I_NONE);

    begin_test("sw_rdy_at_tmo", 32'hAC820004);
    step(S_FETCH, 4'd0, 5'd7, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd7, PCW, I_NONE);
    step(S_MADDR, 4'd0, 5'd7, NONE, I_NONE);
    run_n(14, S_MWR, 5'd7, DRQ | DWE, I_NONE);
    step(S_MWR, 4'd0, 5'd7, DRQ | DWE, I_DRDY);
    step(S_FETCH, 4'd0, 5'd7, IRQ, I_NONE);

    begin_test("ri_3f", 32'hFC000000);
    step(S_FETCH, 4'd0, 5'd7, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd7, PCW, I_NONE);
    step(S_EXC, 4'd12, 5'd10, PCW | EPC, I_NONE);
    step(S_FETCH, 4'd0, 5'd10, IRQ, I_NONE);

    begin_test("div", 32'h0085001A);
    step(S_FETCH, 4'd0, 5'd10, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd10, PCW, I_NONE);
    step(S_MD, 4'd0, 5'd10, MDS, I_BUSY);
    run_n(4, S_MD, 5'd10, NONE, I_BUSY);
    step(S_MD, 4'd0, 5'd10, NONE, I_NONE);
    step(S_FETCH, 4'd0, 5'd10, IRQ, I_NONE);

    begin_test("mtc0", 32'h40826000);
    step(S_FETCH, 4'd0, 5'd10, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd10, PCW, I_NONE);
    step(S_MD, 4'd0, 5'd10, CPW, I_NONE);
    step(S_FETCH, 4'd0, 5'd10, IRQ, I_NONE);

    begin_test("jal", 32'h0C000010);
    step(S_FETCH, 4'd0, 5'd10, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd10, PCW, I_NONE);
    step(S_JMP, 4'd8, 5'd10, PCW | RW, I_NONE);
    step(S_FETCH, 4'd0, 5'd10, IRQ, I_NONE);

    begin_test("eret", 32'h42000018);
    step(S_FETCH, 4'd0, 5'd10, IRQ | IRW, I_IRDY);
    step(S_DECODE, 4'd0, 5'd10, PCW, I_NONE);
    step(S_JMP, 4'd11, 5'd10, PCW | XCL, I_NONE);
    step(S_FETCH, 4'd0, 5'd10, IRQ, I_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
